// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end.
// The command constants name the two prefix bits carried at the top of every received word.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/spi_piso.sv
// Parallel-load serializer that drives MISO MSB first.
// The first bit appears in the cycle after load. MISO stays 0 whenever no bits are pending.
module spi_piso #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic             miso,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    remaining;

  // On load, the MSB is presented immediately and the remaining bits wait in shreg.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      shreg     <= '0;
      remaining <= '0;
      miso      <= 1'b0;
    end else if (load) begin
      miso      <= data[WIDTH-1];
      shreg     <= {data[WIDTH-2:0], 1'b0};
      remaining <= CW'(WIDTH - 1);
    end else if (shift && remaining != '0) begin
      miso      <= shreg[WIDTH-1];
      shreg     <= {shreg[WIDTH-2:0], 1'b0};
      remaining <= remaining - 1'b1;
    end else begin
      miso <= 1'b0;
    end
  end

  assign done = (remaining == '0);

endmodule

// File: rtl/spi_slave.sv
// SPI slave front end: collects MOSI frames into 10-bit RAM command words.
// It also returns RAM read data on MISO after a read-data frame.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SS_n,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic [DATA_WIDTH+1:0] rx_data,
  output logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid
);

  localparam int RX_W  = DATA_WIDTH + 2;
  localparam int CNT_W = $clog2(FRAME_BITS);

  state_t            state, next_state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [RX_W-1:0]   shift_reg;
  logic              frame_done;
  logic              tx_taken;
  logic              rd_addr_done;
  logic              in_data_state;
  logic              in_shift;
  logic              last_bit;
  logic              piso_load;
  logic              piso_shift;
  logic              piso_done;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // The command bit routes a read to READ_DATA only once an address frame has been seen.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!SS_n) next_state = CHK_CMD;
      CHK_CMD: begin
        if (SS_n)              next_state = IDLE;
        else if (!MOSI)        next_state = WRITE;
        else if (rd_addr_done) next_state = READ_DATA;
        else                   next_state = READ_ADD;
      end
      default: if (SS_n) next_state = IDLE;
    endcase
  end

  assign in_data_state = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
  assign in_shift      = in_data_state && !SS_n && !frame_done;
  assign last_bit      = in_shift && (bit_cnt == CNT_W'(FRAME_BITS - 1));
  assign piso_load     = (state == READ_DATA) && !SS_n && frame_done && !tx_taken && tx_valid;
  assign piso_shift    = tx_taken && !piso_done;

  // After a completed frame, frame_done freezes the shifter until SS_n releases the frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      frame_done   <= 1'b0;
      tx_taken     <= 1'b0;
      rd_addr_done <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (SS_n || !in_data_state) begin
        bit_cnt    <= '0;
        shift_reg  <= '0;
        frame_done <= 1'b0;
        tx_taken   <= 1'b0;
      end else begin
        if (in_shift) begin
          shift_reg <= {shift_reg[RX_W-2:0], MOSI};
          bit_cnt   <= bit_cnt + 1'b1;
          if (last_bit) begin
            rx_valid   <= 1'b1;
            rx_data    <= {shift_reg[RX_W-2:0], MOSI};
            frame_done <= 1'b1;
            bit_cnt    <= '0;
            if (state == READ_ADD)  rd_addr_done <= 1'b1;
            if (state == READ_DATA) rd_addr_done <= 1'b0;
          end
        end
        if (piso_load) tx_taken <= 1'b1;
      end
    end
  end

  spi_piso #(
    .WIDTH(DATA_WIDTH)
  ) u_piso (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (SS_n),
    .load  (piso_load),
    .shift (piso_shift),
    .data  (tx_data),
    .miso  (MISO),
    .done  (piso_done)
  );

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave.
// A bit-queue reference model is compared every cycle, alongside literal frame and byte checks.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  spi_slave #(.DATA_WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  // Reference model.
  // pos is -1 when deselected, 0 for the command bit, 1..10 while taking data bits, and 11 after the frame.
  int         pos = -1;
  int         kind = 0;
  int         acc = 0;
  logic       m_rd_done = 1'b0;
  logic       waiting = 1'b0;
  bit         miso_q[$];
  logic       exp_valid = 1'b0;
  logic [9:0] exp_data = '0;
  logic       exp_miso = 1'b0;
  logic       check_en = 1'b0;

  always @(posedge clk) begin
    exp_valid = 1'b0;
    if (!rst_n) begin
      pos = -1; m_rd_done = 1'b0; waiting = 1'b0; exp_data = '0; miso_q.delete();
    end else if (pos < 0) begin
      if (!SS_n) pos = 0;
    end else if (SS_n) begin
      pos = -1; waiting = 1'b0; miso_q.delete();
    end else if (pos == 0) begin
      kind = !MOSI ? 0 : (m_rd_done ? 2 : 1);
      acc  = 0;
      pos  = 1;
    end else if (pos <= 10) begin
      acc = acc * 2 + (MOSI ? 1 : 0);
      pos++;
      if (pos == 11) begin
        exp_valid = 1'b1;
        exp_data  = 10'(acc);
        if (kind == 1) m_rd_done = 1'b1;
        if (kind == 2) m_rd_done = 1'b0;
        waiting = (kind == 2);
      end
    end else if (waiting && tx_valid) begin
      waiting = 1'b0;
      for (int i = 7; i >= 0; i--) miso_q.push_back(tx_data[i]);
    end
    exp_miso = (miso_q.size() > 0) ? miso_q.pop_front() : 1'b0;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model rx_valid", 32'(rx_valid), 32'(exp_valid));
      checkOutput("model rx_data", 32'(rx_data), 32'(exp_data));
      checkOutput("model MISO", 32'(MISO), 32'(exp_miso));
    end
  end

  // Drive SS_n low, then the command bit, then nbits data bits MSB first.
  task automatic applyStimulus(input logic cmd, input logic [9:0] w, input int nbits);
    @(negedge clk); SS_n = 1'b0; MOSI = 1'b0;
    @(negedge clk); MOSI = cmd;
    for (int i = 9; i > 9 - nbits; i--) begin
      @(negedge clk); MOSI = w[i];
    end
  endtask

  task automatic endFrame();
    @(negedge clk); SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic expectWord(input string name, input logic [9:0] lit);
    @(negedge clk);
    checkOutput({name, " rx_valid"}, 32'(rx_valid), 32'd1);
    checkOutput({name, " rx_data"}, 32'(rx_data), 32'(lit));
    checkOutput({name, " model word"}, 32'(exp_data), 32'(lit));
    @(negedge clk);
    checkOutput({name, " pulse end"}, 32'(rx_valid), 32'd0);
  endtask

  task automatic pulseTx(input logic [7:0] d);
    tx_valid = 1'b1; tx_data = d;
  endtask

  task automatic readByte(output logic [7:0] b);
    b = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); tx_valid = 1'b0;
      b = {b[6:0], MISO};
    end
  endtask

  logic [7:0] got;

  initial begin
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("reset rx_data", 32'(rx_data), 32'd0);
    checkOutput("reset MISO", 32'(MISO), 32'd0);
    rst_n = 1'b1; check_en = 1'b1;

    // Write address; a tx_valid pulse during a write must not reach MISO.
    applyStimulus(1'b0, 10'h035, 10);
    expectWord("wr_addr", 10'h035);
    pulseTx(8'hFF);
    repeat (3) @(negedge clk);
    tx_valid = 1'b0;
    checkOutput("wr_addr MISO idle", 32'(MISO), 32'd0);
    endFrame();

    applyStimulus(1'b0, 10'h1A5, 10);
    expectWord("wr_data", 10'h1A5);
    endFrame();

    // Read address followed by read data, serializing 8'hA5.
    applyStimulus(1'b1, 10'h235, 10);
    expectWord("rd_addr", 10'h235);
    pulseTx(8'h77);
    @(negedge clk); tx_valid = 1'b0;
    endFrame();
    applyStimulus(1'b1, 10'h300, 10);
    expectWord("rd_data", 10'h300);
    pulseTx(8'hA5);
    readByte(got);
    checkOutput("rd_data serial byte", 32'(got), 32'hA5);
    @(negedge clk);
    checkOutput("rd_data MISO after byte", 32'(MISO), 32'd0);
    pulseTx(8'hFF);
    repeat (3) @(negedge clk);
    tx_valid = 1'b0;
    checkOutput("rd_data second tx ignored", 32'(MISO), 32'd0);
    endFrame();

    // Read command with no pending address: READ_ADD, no serialization; then READ_DATA follows.
    applyStimulus(1'b1, 10'h2C3, 10);
    expectWord("rd_noaddr", 10'h2C3);
    pulseTx(8'h5A);
    readByte(got);
    checkOutput("rd_noaddr no MISO", 32'(got), 32'h00);
    endFrame();
    applyStimulus(1'b1, 10'h3C3, 10);
    expectWord("rd_after_addr", 10'h3C3);
    pulseTx(8'h3C);
    readByte(got);
    checkOutput("rd_after_addr serial byte", 32'(got), 32'h3C);
    endFrame();

    // Abort after 5 data bits, then a full frame.
    applyStimulus(1'b0, 10'h0AB, 5);
    @(negedge clk); SS_n = 1'b1;
    @(negedge clk);
    checkOutput("abort rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("abort rx_data held", 32'(rx_data), 32'h3C3);
    @(negedge clk);
    applyStimulus(1'b0, 10'h0F0, 10);
    expectWord("after_abort", 10'h0F0);
    endFrame();

    // Reset while MISO is presenting the third bit of 8'hA5.
    applyStimulus(1'b1, 10'h211, 10);
    expectWord("rst_rd_addr", 10'h211);
    endFrame();
    applyStimulus(1'b1, 10'h3AA, 10);
    expectWord("rst_rd_data", 10'h3AA);
    pulseTx(8'hA5);
    @(negedge clk); tx_valid = 1'b0;
    checkOutput("rst bit7", 32'(MISO), 32'd1);
    @(negedge clk);
    checkOutput("rst bit6", 32'(MISO), 32'd0);
    @(negedge clk);
    checkOutput("rst bit5", 32'(MISO), 32'd1);
    rst_n = 1'b0; SS_n = 1'b1;
    @(negedge clk);
    checkOutput("rst MISO cleared", 32'(MISO), 32'd0);
    checkOutput("rst rx_data cleared", 32'(rx_data), 32'd0);
    rst_n = 1'b1;

    // Reset must clear a pending read address, so the next read command is an address frame.
    applyStimulus(1'b1, 10'h2FF, 10);
    expectWord("pend_addr", 10'h2FF);
    @(negedge clk); rst_n = 1'b0; SS_n = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    applyStimulus(1'b1, 10'h3FF, 10);
    expectWord("post_rst_read", 10'h3FF);
    pulseTx(8'hC3);
    readByte(got);
    checkOutput("post_rst_read no MISO", 32'(got), 32'h00);
    endFrame();

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI slave front end that converts MOSI frames into parallel 10-bit command/data words (rx_data, rx_valid) for the single-port RAM.
- Serializes the RAM's 8-bit read data (tx_data, tx_valid) back out on MISO.
- Sits between the SPI pins and the RAM inside the SPI wrapper.
- SPI bit clock equals clk: MOSI is sampled and MISO is updated on posedge clk.

Parameters:
- DATA_WIDTH, 8, RAM data/address width; rx word width is DATA_WIDTH+2.

Ports:
- clk  input  1  system clock, all logic on posedge
- rst_n  input  1  synchronous active-low reset
- SS_n  input  1  slave select, active low; high ends/aborts a frame
- MOSI  input  1  serial data in, MSB first
- MISO  output  1  serial data out, MSB first
- rx_data  output  DATA_WIDTH+2  assembled word: [9:8] command, [7:0] address/data
- rx_valid  output  1  one-cycle pulse, rx_data valid
- tx_data  input  DATA_WIDTH  read data from RAM
- tx_valid  input  1  tx_data valid, sampled only while awaiting read data

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, rx_data=0, rx_valid=0, MISO=0, bit counter=0, rd_addr_done=0. Reset mid-frame aborts with no rx_valid.
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: SS_n=0 sampled -> CHK_CMD.
- CHK_CMD: samples MOSI as the command bit.
  - 0 -> WRITE.
  - 1 and rd_addr_done=0 -> READ_ADD.
  - 1 and rd_addr_done=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA each shift in 10 MOSI bits MSB first, one per clk.
  - rx_valid=1 for exactly the cycle after the 10th bit is sampled, with rx_data holding the full word.
  - rx_data holds its value until the next completed frame.
- Command prefix in the word (00 write addr, 01 write data, 10 read addr, 11 read data) is passed through unchecked.
- Timing: SS_n low seen at edge 0; command bit at edge 1; data bits at edges 2..11; rx_valid high in cycle 12.
- READ_ADD completion sets rd_addr_done=1.
- READ_DATA completion clears rd_addr_done, then waits for tx_valid.
  - tx_valid sampled high at edge N: latch tx_data; MISO=tx_data[7] in cycle N+1 through tx_data[0] in cycle N+8; then MISO=0.
  - Only the first tx_valid per frame is taken.
- After frame completion the FSM stays in its state, with no further rx_valid and MISO=0, until SS_n=1.
- SS_n=1 sampled in any non-IDLE state -> IDLE next cycle.
  - Counter and shifter clear; partial frames produce no rx_valid.
  - MISO returns to 0; rd_addr_done is unchanged.
- tx_valid outside READ_DATA's wait phase is ignored.
- Waiting for tx_valid has no timeout; SS_n=1 exits.
- MISO=0 whenever not actively shifting.

Decomposition:
- Package spi_pkg holds:
  - state enum typedef.
  - command constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - FRAME_BITS=10.
- One sub-module: spi_piso, an 8-bit parallel-load serializer (load, shift, done) driving MISO. The FSM, SIPO and counter stay in spi_slave.

Test Plan:
- Write address: SS_n low, MOSI 0 then 10'b00_0011_0101 -> rx_valid one cycle, rx_data=10'h035, no MISO activity.
- Write data: MOSI 0 then 10'b01_1010_0101 -> rx_data=10'h1A5, one rx_valid pulse, rd_addr_done stays 0.
- Read sequence:
  - Frame 1: MOSI 1, 10'b10_0011_0101 -> rx_data=10'h235, state READ_ADD.
  - Frame 2: MOSI 1, 10'b11_0000_0000 -> rx_data=10'h300, READ_DATA entered.
  - Drive tx_valid with tx_data=8'hA5 one cycle after rx_valid -> MISO serial 1,0,1,0,0,1,0,1 over the next 8 cycles, then 0.
- Read data without prior read address: command bit 1 with rd_addr_done=0 -> READ_ADD taken, rd_addr_done set after frame.
- Abort: SS_n high after 5 data bits -> IDLE next cycle, no rx_valid, rx_data unchanged; next full frame decodes correctly.
- Reset mid-serialization: rst_n=0 during MISO bit 3 of 8'hA5 -> MISO=0, state IDLE, rd_addr_done=0 on next cycle.
